// File: rtl/uart_tx_serializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Serial UART transmitter. Takes the divided baud clock from the clock divider
// as an asynchronous level, edge-detects it in the clk_in domain and shifts a
// parallel word out LSB first as: start(0), DATA_BITS data, optional parity,
// STOP_BITS stop bits (1).
//
// Parameters:
//   DATA_BITS  payload width, 5..9
//   PARITY_EN  1 appends a parity bit after the data bits
//   PARITY_ODD 0 = even parity, 1 = odd parity (only used when PARITY_EN=1)
//   STOP_BITS  1 or 2
//
// Ports:
//   clk_in     system clock, all state updates on its rising edge
//   reset      asynchronous active-high reset, clears all state
//   baud_clk   divided baud clock; each rising edge starts a new bit period
//   tx_data    word to send, sampled only when a request is accepted
//   tx_start   send request
//   tx_busy    high from the cycle after acceptance until the frame completes
//   tx_done    one-cycle pulse in the first idle cycle after a frame
//   tx         registered serial line, idles high
//   dbg_state  current FSM state (0 = idle, 1 = arm, 2 = start, 3 = data,
//              4 = parity, 5 = stop)
//
// Handshake: a request is accepted on the clk_in edge where tx_start=1 and
// tx_busy=0. tx_busy is low in the tx_done cycle, so a request held in that
// cycle is accepted and frames can run back to back. Requests while
// tx_busy=1 are dropped and never queued.
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    localparam int              CNT_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic            ODD_BIT  = (PARITY_ODD != 0);

    state_t                 state_q, state_d;
    logic [2:0]             sync_q, sync_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   parity_q, parity_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   tick;

    // sync_q[0], sync_q[1] form the two-flop synchronizer; sync_q[2] is the
    // delayed copy used for rising-edge detection.
    assign tick = sync_q[1] & ~sync_q[2];

    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[1:0], baud_clk};
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                // A tick landing in the acceptance cycle is deliberately
                // ignored: ARM waits for the next one so the start bit is a
                // full period.
                if (tx_start) begin
                    shift_d   = tx_data;
                    parity_d  = (^tx_data) ^ ODD_BIT;
                    bit_cnt_d = '0;
                    state_d   = S_ARM;
                end
            end
            S_ARM: begin
                if (tick) begin
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d    = S_STOP;
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        // shift_q[0] already holds the next bit to send.
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if ((STOP_BITS == 2) && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sync_q     <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx        = tx_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Three transmitter instances with different frame formats (8N1, 8E1, 7O2)
// share the system clock and a 16-cycle baud clock. Each instance has its own
// driver, a scoreboard that pushes the expected frame when a request should be
// accepted, and a line monitor that decodes the serial line at bit centres and
// checks frame contents, frame length, tx_done and tx_busy.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int BAUD = 16;

    logic clk_in = 1'b0;
    logic baud_clk = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk_in = ~clk_in;

    // Baud clock: exactly BAUD clk_in cycles per period, changing on the
    // falling edge so it is asynchronous to the sampling edge.
    initial begin : baud_gen
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk_in);
            cnt = (cnt + 1) % BAUD;
            baud_clk = (cnt < BAUD / 2);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int DB = (g == 2) ? 7 : 8;
        localparam int PE = (g == 0) ? 0 : 1;
        localparam int PO = (g == 2) ? 1 : 0;
        localparam int SB = (g == 2) ? 2 : 1;
        localparam int NB = 1 + DB + PE + SB;

        logic          rst = 1'b1;
        logic          tx_start = 1'b0;
        logic [DB-1:0] tx_data = '0;
        logic          tx_busy;
        logic          tx_done;
        logic          tx;
        logic [2:0]    dbg_state;

        uart_tx_serializer #(
            .DATA_BITS (DB),
            .PARITY_EN (PE),
            .PARITY_ODD(PO),
            .STOP_BITS (SB)
        ) dut (
            .clk_in   (clk_in),
            .reset    (rst),
            .baud_clk (baud_clk),
            .tx_data  (tx_data),
            .tx_start (tx_start),
            .tx_busy  (tx_busy),
            .tx_done  (tx_done),
            .tx       (tx),
            .dbg_state(dbg_state)
        );

        logic [15:0] exp_q[$];
        int          acc_q[$];
        bit          model_busy = 1'b0;
        bit          drv_done = 1'b0;
        int          done_cnt = 0;
        int          frames_end = 0;

        // Reference frame: bit i of the result is the i-th bit on the line.
        function automatic logic [15:0] model_frame(input logic [DB-1:0] d);
            logic [15:0] f;
            f = '0;
            for (int i = 0; i < DB; i++) f[1 + i] = d[i];
            if (PE != 0) f[1 + DB] = ((($countones(d) + PO) % 2) == 1);
            for (int i = 1 + DB + PE; i < NB; i++) f[i] = 1'b1;
            return f;
        endfunction

        // Scoreboard and line monitor in one process: request sampling on the
        // rising edge, line observation on the falling edge.
        initial begin : sb_mon
            int          cyc;
            int          off;
            int          t0;
            int          lat;
            bit          accepted;
            bit          rx_active;
            bit          busy_bad;
            logic [15:0] rx_bits;
            cyc = 0; t0 = 0; rx_active = 0; busy_bad = 0; rx_bits = '0;
            forever begin
                @(posedge clk_in);
                accepted = 0;
                if (!rst && tx_start && !model_busy) begin
                    exp_q.push_back(model_frame(tx_data));
                    acc_q.push_back(cyc);
                    model_busy = 1;
                    accepted = 1;
                end
                @(negedge clk_in);
                cyc++;
                if (rst) begin
                    rx_active = 0;
                    model_busy = 0;
                    exp_q.delete();
                    acc_q.delete();
                end else begin
                    if (accepted) check($sformatf("u%0d_busy_after_accept", g), tx_busy, 1);
                    if (tx_done) done_cnt++;
                    if (!rx_active) begin
                        if (tx == 1'b0) begin
                            rx_active = 1;
                            t0 = cyc;
                            rx_bits = '0;
                            busy_bad = 0;
                            check($sformatf("u%0d_start_has_request", g), acc_q.size(), 1);
                            if (acc_q.size() > 0) begin
                                lat = cyc - acc_q.pop_front();
                                check($sformatf("u%0d_start_latency_2_to_17", g),
                                      int'(lat >= 2 && lat <= BAUD + 1), 1);
                            end
                        end
                    end else begin
                        off = cyc - t0;
                        if (off < NB * BAUD) begin
                            if (off % BAUD == BAUD / 2) rx_bits[off / BAUD] = tx;
                            if (!tx_busy) busy_bad = 1;
                        end else begin
                            frames_end++;
                            check($sformatf("u%0d_done_at_frame_end", g), tx_done, 1);
                            check($sformatf("u%0d_busy_low_in_done", g), tx_busy, 0);
                            check($sformatf("u%0d_busy_held_in_frame", g), busy_bad, 0);
                            check($sformatf("u%0d_frame_expected", g), exp_q.size(), 1);
                            if (exp_q.size() > 0)
                                check($sformatf("u%0d_frame_bits", g), rx_bits, exp_q.pop_front());
                            rx_active = 0;
                            model_busy = 0;
                        end
                    end
                end
            end
        end

        task automatic wait_idle(input int budget);
            int n;
            n = 0;
            while (model_busy && n < budget) begin
                @(negedge clk_in);
                n++;
            end
            check($sformatf("u%0d_idle_within_budget", g), model_busy, 0);
        endtask

        task automatic send(input int d);
            wait_idle(2000);
            @(negedge clk_in);
            tx_start = 1'b1;
            tx_data  = DB'(d);
            @(negedge clk_in);
            tx_start = 1'b0;
            tx_data  = DB'($urandom);
        endtask

        initial begin : drv
            int n;
            bit seen;
            repeat (3) @(negedge clk_in);
            check($sformatf("u%0d_reset_tx", g), tx, 1);
            check($sformatf("u%0d_reset_busy", g), tx_busy, 0);
            check($sformatf("u%0d_reset_done", g), tx_done, 0);
            check($sformatf("u%0d_reset_state", g), dbg_state, 0);
            rst = 1'b0;
            repeat (5) @(negedge clk_in);

            send(8'h55);
            send(8'hA3);

            // Request while busy must be dropped.
            send(8'h0F);
            repeat (40) @(negedge clk_in);
            tx_start = 1'b1;
            tx_data  = DB'(8'hFF);
            @(negedge clk_in);
            tx_start = 1'b0;

            // Back-to-back: request held in the tx_done cycle.
            send(8'h00);
            n = 0;
            seen = 0;
            while (!seen && n < 2000) begin
                @(negedge clk_in);
                n++;
                if (tx_done) seen = 1;
            end
            check($sformatf("u%0d_b2b_done_seen", g), seen, 1);
            tx_start = 1'b1;
            tx_data  = DB'(8'hFF);
            @(negedge clk_in);
            tx_start = 1'b0;

            // Reset in the middle of data bit 3.
            send(8'h3C);
            n = 0;
            while (tx !== 1'b0 && n < 200) begin
                @(negedge clk_in);
                n++;
            end
            check($sformatf("u%0d_rst_frame_started", g), tx, 0);
            repeat (4 * BAUD + BAUD / 2) @(negedge clk_in);
            rst = 1'b1;
            #1;
            check($sformatf("u%0d_midrst_tx", g), tx, 1);
            check($sformatf("u%0d_midrst_busy", g), tx_busy, 0);
            check($sformatf("u%0d_midrst_done", g), tx_done, 0);
            repeat (3) @(negedge clk_in);
            rst = 1'b0;
            repeat (2) @(negedge clk_in);
            send(8'h81);
            send(8'hC6);

            repeat (6) begin
                repeat ($urandom_range(0, 40)) @(negedge clk_in);
                send(int'($urandom_range(0, 511)));
            end

            wait_idle(2000);
            repeat (40) @(negedge clk_in);
            check($sformatf("u%0d_done_pulse_count", g), done_cnt, frames_end);
            check($sformatf("u%0d_no_pending_frames", g), exp_q.size(), 0);
            drv_done = 1'b1;
        end
    end

    initial begin : main
        int n;
        n = 0;
        while (!(u[0].drv_done && u[1].drv_done && u[2].drv_done) && n < 30000) begin
            @(negedge clk_in);
            n++;
        end
        check("all_drivers_finished",
              int'(u[0].drv_done) + int'(u[1].drv_done) + int'(u[2].drv_done), 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
